alu_wb_queue: RTL and testbench

Writeback buffer directly downstream of alu_core, decoupling the execute stage from register-file writeback. It accepts one ALU result per cycle (result, zero, overflow, destination register) over a valid/ready handshake and holds it in a DEPTH-entry FIFO. Writes to x0 are dropped. The block also keeps a sticky overflow flag and a saturating overflow event counter for debug and trap logic.

---
 rtl/alu_wb_queue.sv | 104 ++++++++++
 tb/tb_alu_wb_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_queue.sv
// Writeback buffer between alu_core and the register file: a DEPTH-entry FIFO of ALU results
// with x0 writes dropped, plus sticky overflow flag and saturating overflow event counter.
module alu_wb_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_overflow,
    input  logic [4:0]               in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic [4:0]               out_rd,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic                     clr_ovf,
    output logic                     ovf_sticky,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]      OccFull = (AW+1)'(DEPTH);
    localparam logic [AW:0]      OccOne  = (AW+1)'(1);
    localparam logic [AW-1:0]    PtrOne  = AW'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [WIDTH-1:0] mem_result_q [DEPTH];
    logic             mem_zero_q   [DEPTH];
    logic [4:0]       mem_rd_q     [DEPTH];

    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      occ_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, push, pop;

    // Full queue still accepts when the head drains in the same cycle.
    assign in_ready  = !rst && ((occ_q != OccFull) || out_ready);
    assign out_valid = (occ_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (in_rd != 5'd0);
    assign pop       = out_valid && out_ready;

    assign out_result = mem_result_q[head_q];
    assign out_zero   = mem_zero_q[head_q];
    assign out_rd     = mem_rd_q[head_q];
    assign occupancy  = occ_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_result_q[i] <= '0;
                mem_zero_q[i]   <= 1'b0;
                mem_rd_q[i]     <= '0;
            end
        end else if (push) begin
            mem_result_q[tail_q] <= in_result;
            mem_zero_q[tail_q]   <= in_zero;
            mem_rd_q[tail_q]     <= in_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) tail_q <= tail_q + PtrOne;
            if (pop)  head_q <= head_q + PtrOne;
            if (push && !pop)      occ_q <= occ_q + OccOne;
            else if (pop && !push) occ_q <= occ_q - OccOne;
        end
    end

    // Clear takes effect before a coincident overflow increment.
    always_comb begin
        sticky_d = clr_ovf ? 1'b0 : sticky_q;
        cnt_d    = clr_ovf ? '0 : cnt_q;
        if (accept && in_overflow) begin
            sticky_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_wb_queue.sv
// Randomised and directed bench for alu_wb_queue: a queue-based reference model predicts
// accepts, pops and overflow accounting; a negedge monitor compares against the DUT.
module tb_alu_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_zero = 1'b0, in_overflow = 1'b0, out_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] in_result = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, out_valid, out_zero, ovf_sticky;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [2:0]  occupancy;
    logic [7:0]  ovf_count;

    logic        in_ready2, out_valid2, out_zero2, ovf_sticky2;
    logic [31:0] out_result2;
    logic [4:0]  out_rd2;
    logic [2:0]  occupancy2;
    logic [1:0]  ovf_count2;

    int n_pass = 0;
    int n_tot  = 0;

    ent_t exp_q[$];
    int   m_cnt = 0, m_cnt2 = 0;
    bit   m_sticky = 0;

    alu_wb_queue #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .occupancy(occupancy), .clr_ovf(clr_ovf),
        .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation at 3.
    alu_wb_queue #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow), .in_rd(in_rd),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_zero(out_zero2), .out_rd(out_rd2), .occupancy(occupancy2), .clr_ovf(clr_ovf),
        .ovf_sticky(ovf_sticky2), .ovf_count(ovf_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Monitor / scoreboard: compares state just before each rising edge, then advances model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_result", out_result, 32'd0);
            chk("rst_ovf_count", 32'(ovf_count), 32'd0);
            chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
            exp_q.delete();
            m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
        end else begin
            bit exp_ready, acc, pp;
            ent_t e;
            exp_ready = (exp_q.size() < DEPTH) || out_ready;
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
            chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
            chk("ovf_count_w2", 32'(ovf_count2), 32'(m_cnt2));
            chk("ovf_sticky_w2", 32'(ovf_sticky2), 32'(m_sticky));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("out_result", out_result, e.r);
                chk("out_zero", 32'(out_zero), 32'(e.z));
                chk("out_rd", 32'(out_rd), 32'(e.rd));
            end
            acc = in_valid && exp_ready;
            pp  = (exp_q.size() != 0) && out_ready;
            if (pp) void'(exp_q.pop_front());
            if (acc && in_rd != 5'd0) exp_q.push_back('{r: in_result, z: in_zero, rd: in_rd});
            if (clr_ovf) begin
                m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
            end
            if (acc && in_overflow) begin
                m_sticky = 1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    task automatic beat(input bit v, input logic [4:0] rd, input logic [31:0] r, input bit z,
                        input bit ovf, input bit ordy, input bit clr);
        in_valid = v; in_rd = rd; in_result = r; in_zero = z;
        in_overflow = ovf; out_ready = ordy; clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Single push, visible after one edge.
        beat(1, 5'd5, 32'h8, 0, 0, 0, 0);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_out_result", out_result, 32'h8);
        chk("first_out_rd", 32'(out_rd), 32'd5);
        idle(1, 3);

        // Fill, then push-while-full with simultaneous pop.
        for (int i = 1; i <= 4; i++) beat(1, 5'(i), 32'(i * 32'h11), 0, 0, 0, 0);
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        beat(1, 5'd6, 32'h66, 1, 0, 1, 0);
        idle(1, 6);

        // x0 drop.
        beat(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("x0_not_stored", 32'(occupancy), 32'd0);
        beat(1, 5'd7, 32'h2, 0, 0, 0, 0);
        idle(1, 3);

        // Overflow on an x0 beat, then clear together with another overflow.
        beat(1, 5'd0, 32'h8000_0000, 0, 1, 1, 0);
        chk("ovf_x0_count", 32'(ovf_count), 32'd1);
        beat(1, 5'd0, 32'h8000_0000, 0, 1, 1, 1);
        chk("clr_with_ovf_count", 32'(ovf_count), 32'd1);
        chk("clr_with_ovf_sticky", 32'(ovf_sticky), 32'd1);

        // Narrow counter saturation, then wide counter saturation.
        for (int i = 0; i < 5; i++) beat(1, 5'd0, 32'd0, 0, 1, 1, 0);
        chk("sat_w2", 32'(ovf_count2), 32'd3);
        for (int i = 0; i < 270; i++) beat(1, 5'd0, 32'd0, 0, 1, 1, 0);
        chk("sat_w8", 32'(ovf_count), 32'd255);
        beat(0, 5'd0, 32'd0, 0, 1, 1, 1);
        beat(0, 5'd0, 32'd0, 0, 1, 1, 0);
        chk("unaccepted_ovf", 32'(ovf_count), 32'd0);

        // Asynchronous reset between edges with three stored entries.
        for (int i = 1; i <= 3; i++) beat(1, 5'(i + 8), 32'(i + 100), 0, 0, 0, 0);
        in_valid = 0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        beat(1, 5'd12, 32'hABCD, 1, 0, 0, 0);
        chk("post_rst_occ", 32'(occupancy), 32'd1);
        chk("post_rst_result", out_result, 32'hABCD);
        idle(1, 2);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            beat($urandom_range(0, 9) < 7, rd, $urandom, 1'($urandom),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 3);
        end
        idle(1, 8);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
